// File: rtl/kl_req_arb.sv
// Two-master KLink arbiter and response router in front of the MLink transceiver.
// Define KL_REQ_ARB_RR_EN for round-robin arbitration; fixed priority (m0 first) otherwise.
module kl_req_arb #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_req_addr,
  input  logic        m0_req_den,
  input  logic [63:0] m0_req_data,
  input  logic [2:0]  m0_req_size,
  input  logic [3:0]  m0_req_tag,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  output logic [31:0] m0_rsp_addr,
  output logic [63:0] m0_rsp_data,
  output logic        m0_rsp_den,
  output logic [2:0]  m0_rsp_size,
  output logic [3:0]  m0_rsp_tag,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  input  logic [31:0] m1_req_addr,
  input  logic        m1_req_den,
  input  logic [63:0] m1_req_data,
  input  logic [2:0]  m1_req_size,
  input  logic [3:0]  m1_req_tag,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  output logic [31:0] m1_rsp_addr,
  output logic [63:0] m1_rsp_data,
  output logic        m1_rsp_den,
  output logic [2:0]  m1_rsp_size,
  output logic [3:0]  m1_rsp_tag,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] kl_tx_addr,
  output logic        kl_tx_den,
  output logic [63:0] kl_tx_data,
  output logic [2:0]  kl_tx_size,
  output logic [4:0]  kl_tx_id,
  output logic        kl_tx_valid,
  input  logic        kl_tx_ready,
  input  logic [31:0] kl_rx_addr,
  input  logic [63:0] kl_rx_data,
  input  logic        kl_rx_den,
  input  logic [2:0]  kl_rx_size,
  input  logic [4:0]  kl_rx_id,
  input  logic        kl_rx_valid,
  output logic        kl_rx_ready,
  output logic        err_unexp
);

  localparam logic T_IDLE  = 1'b0;
  localparam logic T_BURST = 1'b1;
  localparam logic R_IDLE  = 1'b0;
  localparam logic R_BURST = 1'b1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  function automatic logic [4:0] beat_count(input logic den, input logic [2:0] size);
    logic [4:0] b;
    b = 5'd1;
    if (den && (size > 3'd3)) b = 5'd1 << (size - 3'd3);
    return b;
  endfunction

  // Returns {unexpected_completion, next_count}.
  function automatic logic [4:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [4:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) r = {1'b0, cnt + 4'd1};
    else if (dec && !inc) r = (cnt == '0) ? {1'b1, 4'd0} : {1'b0, cnt - 4'd1};
    return r;
  endfunction

  logic       tx_state;
  logic       tx_lock;
  logic [4:0] tx_cnt;
  logic       rx_state;
  logic       rx_lock;
  logic [4:0] rx_cnt;
  logic [3:0] out0_cnt;
  logic [3:0] out1_cnt;
  logic       hold_vld;
  logic       hold_idx;
  logic       err_q;

  logic       elig0, elig1;
  logic       arb_idx, arb_any;
  logic       tx_sel, tx_act;
  logic       sel_valid;
  logic       tx_fire, tx_first;
  logic [4:0] tx_beats;
  logic       rx_tgt, rx_fire, rx_last;
  logic [4:0] rx_beats;
  logic       inc0, inc1, dec0, dec1;
  logic [4:0] nxt0, nxt1;

  assign elig0 = m0_req_valid && (out0_cnt < MAX_CNT);
  assign elig1 = m1_req_valid && (out1_cnt < MAX_CNT);
  assign arb_any = elig0 || elig1;

`ifdef KL_REQ_ARB_RR_EN
  logic rr_ptr;

  always_comb begin
    arb_idx = 1'b0;
    if (elig0 && elig1) arb_idx = rr_ptr;
    else                arb_idx = elig1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rr_ptr <= 1'b0;
    else if (tx_first) rr_ptr <= ~tx_sel;
  end
`else
  always_comb begin
    arb_idx = 1'b0;
    if (!elig0) arb_idx = elig1;
  end
`endif

  // A beat offered but not accepted is held to the same master even if
  // the other master becomes eligible in the meantime.
  always_comb begin
    tx_sel = 1'b0;
    tx_act = 1'b0;
    if (tx_state == T_BURST) begin
      tx_sel = tx_lock;
      tx_act = 1'b1;
    end else if (hold_vld && (hold_idx ? m1_req_valid : m0_req_valid)) begin
      tx_sel = hold_idx;
      tx_act = 1'b1;
    end else begin
      tx_sel = arb_idx;
      tx_act = arb_any;
    end
  end

  assign sel_valid   = tx_sel ? m1_req_valid : m0_req_valid;
  assign kl_tx_valid = tx_act && sel_valid;
  assign kl_tx_addr  = tx_sel ? m1_req_addr : m0_req_addr;
  assign kl_tx_den   = tx_sel ? m1_req_den  : m0_req_den;
  assign kl_tx_data  = tx_sel ? m1_req_data : m0_req_data;
  assign kl_tx_size  = tx_sel ? m1_req_size : m0_req_size;
  assign kl_tx_id    = {tx_sel, (tx_sel ? m1_req_tag : m0_req_tag)};
  assign m0_req_ready = tx_act && !tx_sel && kl_tx_ready;
  assign m1_req_ready = tx_act &&  tx_sel && kl_tx_ready;

  assign tx_fire  = kl_tx_valid && kl_tx_ready;
  assign tx_first = tx_fire && (tx_state == T_IDLE);
  assign tx_beats = beat_count(kl_tx_den, kl_tx_size);
  assign inc0     = tx_first && !tx_sel;
  assign inc1     = tx_first &&  tx_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_lock  <= 1'b0;
      tx_cnt   <= '0;
      hold_vld <= 1'b0;
      hold_idx <= 1'b0;
    end else begin
      hold_vld <= (tx_state == T_IDLE) && kl_tx_valid && !kl_tx_ready;
      hold_idx <= tx_sel;
      if (tx_state == T_IDLE) begin
        if (tx_first && (tx_beats != 5'd1)) begin
          tx_state <= T_BURST;
          tx_lock  <= tx_sel;
          tx_cnt   <= tx_beats - 5'd1;
        end
      end else if (tx_fire) begin
        if (tx_cnt == 5'd1) tx_state <= T_IDLE;
        tx_cnt <= tx_cnt - 5'd1;
      end
    end
  end

  assign rx_tgt       = (rx_state == R_BURST) ? rx_lock : kl_rx_id[4];
  assign m0_rsp_valid = kl_rx_valid && !rx_tgt;
  assign m1_rsp_valid = kl_rx_valid &&  rx_tgt;
  assign kl_rx_ready  = rx_tgt ? m1_rsp_ready : m0_rsp_ready;

  assign m0_rsp_addr = kl_rx_addr;
  assign m0_rsp_data = kl_rx_data;
  assign m0_rsp_den  = kl_rx_den;
  assign m0_rsp_size = kl_rx_size;
  assign m0_rsp_tag  = kl_rx_id[3:0];
  assign m1_rsp_addr = kl_rx_addr;
  assign m1_rsp_data = kl_rx_data;
  assign m1_rsp_den  = kl_rx_den;
  assign m1_rsp_size = kl_rx_size;
  assign m1_rsp_tag  = kl_rx_id[3:0];

  assign rx_fire  = kl_rx_valid && kl_rx_ready;
  assign rx_beats = beat_count(kl_rx_den, kl_rx_size);
  assign rx_last  = rx_fire && ((rx_state == R_IDLE) ? (rx_beats == 5'd1) : (rx_cnt == 5'd1));
  assign dec0     = rx_last && !rx_tgt;
  assign dec1     = rx_last &&  rx_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
      rx_lock  <= 1'b0;
      rx_cnt   <= '0;
    end else if (rx_state == R_IDLE) begin
      if (rx_fire && (rx_beats != 5'd1)) begin
        rx_state <= R_BURST;
        rx_lock  <= rx_tgt;
        rx_cnt   <= rx_beats - 5'd1;
      end
    end else if (rx_fire) begin
      if (rx_cnt == 5'd1) rx_state <= R_IDLE;
      rx_cnt <= rx_cnt - 5'd1;
    end
  end

  always_comb begin
    nxt0 = cnt_next(out0_cnt, inc0, dec0);
    nxt1 = cnt_next(out1_cnt, inc1, dec1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_cnt <= '0;
      out1_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      out0_cnt <= nxt0[3:0];
      out1_cnt <= nxt1[3:0];
      err_q    <= err_q | nxt0[4] | nxt1[4];
    end
  end

  assign err_unexp = err_q;

endmodule
